stopwatch_lap: RTL

Parametrised next-generation stopwatch for the seven-segment display path: an N-digit BCD time counter with built-in tick prescaler, count-up or count-down mode, lap freeze, parallel load and terminal-event flags. It replaces the fixed four-digit chain plus external divider and drives the display mux directly from `digits`.

---
 rtl/stopwatch_lap.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: N-digit BCD stopwatch with built-in tick prescaler,
// up/down counting, lap freeze, parallel load and terminal-event flags.
//
// Ports:
//   clk, reset      system clock; synchronous active-low reset
//   run             level, enables the prescaler
//   mode            0 = count up, 1 = count down
//   clear           pulse, zeroes prescaler, count, lap state and halted
//   load            pulse, loads load_value (clamped per digit)
//   load_value      BCD preload, digit 0 in bits [3:0]
//   lap             pulse, toggles the lap freeze
//   digits          displayed value (lap register while frozen, else count)
//   count           live BCD count
//   lap_active      display frozen on the captured value
//   tick            combinational count-enable strobe
//   overflow        one-cycle pulse on up-count wrap
//   done            one-cycle pulse when a down-count reaches zero
module stopwatch_lap #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned TICK_DIV   = 1000000,
   parameter int unsigned TOP_MOD    = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    mode,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    lap,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    lap_active,
   output logic                    tick,
   output logic                    overflow,
   output logic                    done
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned CW = 4 * NUM_DIGITS;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0] TOP_MAX = 4'(TOP_MOD - 1);

   // Largest legal value of digit i.
   function automatic logic [3:0] digit_max(input int unsigned i);
      return (i == NUM_DIGITS - 1) ? TOP_MAX : 4'd9;
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] lap_q, lap_d;
   logic          lap_active_q, lap_active_d;
   logic          halted_q, halted_d;
   logic          overflow_q, overflow_d;
   logic          done_q, done_d;

   logic          count_zero;
   logic          presc_en;
   logic          tick_c;
   logic [CW-1:0] inc_val;
   logic          inc_carry;
   logic [CW-1:0] dec_val;
   logic [CW-1:0] load_clamp;

   // Prescaler enable; a zero count in down mode freezes it (no underflow).
   assign count_zero = (count_q == '0);
   assign presc_en   = run & ~halted_q & ~(mode & count_zero);
   assign tick_c     = reset & presc_en & (presc_q == PRESC_LAST);

   // Ripple-carry BCD increment across all digits.
   always_comb begin
      logic carry;
      inc_val = count_q;
      carry   = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (count_q[4*i +: 4] >= digit_max(i)) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
      inc_carry = carry;
   end

   // Ripple-borrow BCD decrement; a borrowing digit reloads its maximum.
   always_comb begin
      logic borrow;
      dec_val = count_q;
      borrow  = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = digit_max(i);
            end else begin
               dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   // Per-digit clamp of the preload value.
   always_comb begin
      load_clamp = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (load_value[4*i +: 4] > digit_max(i)) begin
            load_clamp[4*i +: 4] = digit_max(i);
         end else begin
            load_clamp[4*i +: 4] = load_value[4*i +: 4];
         end
      end
   end

   // Next-state logic: clear > load > tick update; lap handled alongside.
   always_comb begin
      presc_d      = presc_q;
      count_d      = count_q;
      lap_d        = lap_q;
      lap_active_d = lap_active_q;
      halted_d     = halted_q;
      overflow_d   = 1'b0;
      done_d       = 1'b0;

      // Leaving down mode releases the halt.
      if (!mode) begin
         halted_d = 1'b0;
      end

      if (presc_en) begin
         presc_d = tick_c ? '0 : presc_q + PW'(1);
      end

      if (tick_c) begin
         if (!mode) begin
            count_d    = inc_val;
            overflow_d = inc_carry;
         end else begin
            count_d = dec_val;
            if (dec_val == '0) begin
               done_d   = 1'b1;
               halted_d = 1'b1;
            end
         end
      end

      // Lap captures the pre-update count.
      if (lap) begin
         if (!lap_active_q) begin
            lap_d        = count_q;
            lap_active_d = 1'b1;
         end else begin
            lap_active_d = 1'b0;
         end
      end

      if (clear) begin
         presc_d      = '0;
         count_d      = '0;
         lap_d        = '0;
         lap_active_d = 1'b0;
         halted_d     = 1'b0;
         overflow_d   = 1'b0;
         done_d       = 1'b0;
      end else if (load) begin
         presc_d    = '0;
         count_d    = load_clamp;
         halted_d   = 1'b0;
         overflow_d = 1'b0;
         done_d     = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q      <= '0;
         count_q      <= '0;
         lap_q        <= '0;
         lap_active_q <= 1'b0;
         halted_q     <= 1'b0;
         overflow_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         count_q      <= count_d;
         lap_q        <= lap_d;
         lap_active_q <= lap_active_d;
         halted_q     <= halted_d;
         overflow_q   <= overflow_d;
         done_q       <= done_d;
      end
   end

   assign digits     = lap_active_q ? lap_q : count_q;
   assign count      = count_q;
   assign lap_active = lap_active_q;
   assign tick       = tick_c;
   assign overflow   = overflow_q;
   assign done       = done_q;

endmodule
